bit_scan_iterator: RTL and testbench

Sequential successor to the combinational lsb/msb find logic. It accepts an N-bit mask and emits the index of every matching bit, one per cycle, in scan order (LSB-first or MSB-first). It clears each bit as it is emitted and flags the final beat. It sits between a mask producer (e.g. lane-active or bank-request vectors) and a per-element consumer that handles one item per cycle.

---
 rtl/bit_scan_iterator.sv | 127 ++++++++++++
 tb/tb_bit_scan_iterator.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_scan_iterator.sv
// Purpose: iterate over the matching bits of an N-bit mask, one index per beat, LSB- or MSB-first.
// Latency: 1 cycle from mask load to first beat; 1 beat/cycle under continuous i_dst_ack.
// Backpressure: a beat holds while i_dst_ack is low; a new mask is taken only in IDLE or on the acked last beat.
// Optional: define BIT_SCAN_ITERATOR_EMPTY_BEAT_EN to emit a single o_empty beat for an all-zero mask.
module bit_scan_iterator #(
    parameter int N         = 10,
    parameter bit MSB_FIRST = 1'b0,
    parameter bit ONE       = 1'b1,
    localparam int IW       = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_src_rdy,
    output logic          o_src_ack,
    input  logic [N-1:0]  i_mask,
    output logic          o_dst_rdy,
    input  logic          i_dst_ack,
    output logic [IW-1:0] o_idx,
    output logic [N-1:0]  o_onehot,
    output logic          o_last,
    output logic          o_empty
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [N-1:0]  mask_r, mask_n;
    logic [N-1:0]  hit;
    logic [IW-1:0] hit_idx;
    logic [N-1:0]  load_mask;
    logic          busy;
    logic          load;

    // Working mask is stored post-inversion so the scan always looks for ones.
    assign load_mask = ONE ? i_mask : ~i_mask;
    assign busy      = (state == BUSY);

    // Prefix-OR scan from the selected end: a bit wins if no earlier bit in scan order is set.
    always_comb begin
        logic seen;
        seen = 1'b0;
        hit  = '0;
        if (!MSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                hit[i] = mask_r[i] & ~seen;
                seen   = seen | mask_r[i];
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                hit[i] = mask_r[i] & ~seen;
                seen   = seen | mask_r[i];
            end
        end
    end

    // Binary encode of the one-hot winner (zero when nothing is set).
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (hit[i]) begin
                hit_idx = hit_idx | IW'(i);
            end
        end
    end

    // All beat outputs come from registers only; IDLE forces them to zero.
    assign o_dst_rdy = busy;
    assign o_onehot  = busy ? hit : '0;
    assign o_idx     = busy ? hit_idx : '0;
    assign o_last    = busy && ((mask_r & ~hit) == '0);
`ifdef BIT_SCAN_ITERATOR_EMPTY_BEAT_EN
    assign o_empty   = busy && (mask_r == '0);
`else
    assign o_empty   = 1'b0;
`endif

    // Accepting on the acked last beat lets the next mask follow without a bubble.
    assign o_src_ack = !busy || (i_dst_ack && o_last);
    assign load      = i_src_rdy && o_src_ack;

    // Next-state: retire the current bit on transfer; a load overrides the return to IDLE.
    always_comb begin
        state_n = state;
        mask_n  = mask_r;
        case (state)
            IDLE: begin
                state_n = IDLE;
            end
            BUSY: begin
                if (i_dst_ack) begin
                    if (o_last) begin
                        state_n = IDLE;
                    end else begin
                        mask_n = mask_r & ~hit;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (load) begin
            mask_n = load_mask;
`ifdef BIT_SCAN_ITERATOR_EMPTY_BEAT_EN
            state_n = BUSY;
`else
            // An all-zero mask is consumed silently.
            state_n = (load_mask != '0) ? BUSY : IDLE;
`endif
        end
    end

    // State and working-mask registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            mask_r <= '0;
        end else begin
            state  <= state_n;
            mask_r <= mask_n;
        end
    end

endmodule

// File: tb/tb_bit_scan_iterator.sv
// Bench for bit_scan_iterator: three instances (LSB/ONE=1, MSB/ONE=1, MSB/ONE=0).
// Expected beats and point probes are queued by the stimulus and checked by a negedge monitor.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_bit_scan_iterator;

    localparam int N  = 10;
    localparam int IW = 4;

    localparam int P_ACK  = 0;
    localparam int P_RDY  = 1;
    localparam int P_QEMP = 2;
    localparam int P_IDX  = 3;
    localparam int P_OH   = 4;
    localparam int P_LAST = 5;
    localparam int P_EMP  = 6;

    typedef struct {
        int            g;
        logic [IW-1:0] idx;
        logic [N-1:0]  oh;
        logic          last;
        logic          emp;
    } beat_t;

    typedef struct {
        int           g;
        int           kind;
        logic [N-1:0] val;
        string        nm;
    } probe_t;

    logic          clk;
    logic          rst;
    logic          src_rdy [3];
    logic          src_ack [3];
    logic [N-1:0]  mask    [3];
    logic          dst_rdy [3];
    logic          dst_ack [3];
    logic [IW-1:0] idx     [3];
    logic [N-1:0]  onehot  [3];
    logic          last    [3];
    logic          empty   [3];

    beat_t  expq[$];
    probe_t probeq[$];
    int     errors;
    int     checks;

    logic          hold_v    [3];
    logic [IW-1:0] hold_idx  [3];
    logic [N-1:0]  hold_oh   [3];
    logic          hold_last [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bit_scan_iterator #(
            .N(N),
            .MSB_FIRST((g == 0) ? 1'b0 : 1'b1),
            .ONE((g == 2) ? 1'b0 : 1'b1)
        ) dut (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_src_rdy (src_rdy[g]),
            .o_src_ack (src_ack[g]),
            .i_mask    (mask[g]),
            .o_dst_rdy (dst_rdy[g]),
            .i_dst_ack (dst_ack[g]),
            .o_idx     (idx[g]),
            .o_onehot  (onehot[g]),
            .o_last    (last[g]),
            .o_empty   (empty[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: hold stability, scoreboard pops on transfers, then queued probes.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (hold_v[g]) begin
                checks++;
                if (!(dst_rdy[g] && idx[g] == hold_idx[g] && onehot[g] == hold_oh[g] && last[g] == hold_last[g])) begin
                    errors++;
                    $display("FAIL hold dut%0d: got rdy=%0d idx=%0d oh=%h last=%0d, required idx=%0d oh=%h last=%0d held",
                             g, dst_rdy[g], idx[g], onehot[g], last[g], hold_idx[g], hold_oh[g], hold_last[g]);
                end
            end
            hold_v[g]    = dst_rdy[g] && !dst_ack[g] && !rst;
            hold_idx[g]  = idx[g];
            hold_oh[g]   = onehot[g];
            hold_last[g] = last[g];

            if (dst_rdy[g] && dst_ack[g] && !rst) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL beat dut%0d: unexpected beat idx=%0d oh=%h last=%0d, required none", g, idx[g], onehot[g], last[g]);
                end else begin
                    beat_t e;
                    e = expq.pop_front();
                    if (e.g != g || e.idx !== idx[g] || e.oh !== onehot[g] || e.last !== last[g] || e.emp !== empty[g]) begin
                        errors++;
                        $display("FAIL beat dut%0d: got idx=%0d oh=%h last=%0d empty=%0d, required dut%0d idx=%0d oh=%h last=%0d empty=%0d",
                                 g, idx[g], onehot[g], last[g], empty[g], e.g, e.idx, e.oh, e.last, e.emp);
                    end
                end
            end
        end

        while (probeq.size() > 0) begin
            probe_t p;
            logic [N-1:0] act;
            p = probeq.pop_front();
            case (p.kind)
                P_ACK:   act = N'(src_ack[p.g]);
                P_RDY:   act = N'(dst_rdy[p.g]);
                P_QEMP:  act = N'(expq.size());
                P_IDX:   act = N'(idx[p.g]);
                P_OH:    act = onehot[p.g];
                P_LAST:  act = N'(last[p.g]);
                default: act = N'(empty[p.g]);
            endcase
            checks++;
            if (act !== p.val) begin
                errors++;
                $display("FAIL %s dut%0d: got %h, required %h", p.nm, p.g, act, p.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int g, input int kind, input logic [N-1:0] val, input string nm);
        probe_t p;
        p.g = g; p.kind = kind; p.val = val; p.nm = nm;
        probeq.push_back(p);
    endtask

    task automatic exp_beat(input int g, input int i, input logic [N-1:0] oh, input logic lst, input logic emp);
        beat_t b;
        b.g = g; b.idx = IW'(i); b.oh = oh; b.last = lst; b.emp = emp;
        expq.push_back(b);
    endtask

    // Presents one mask from IDLE; the block must accept it on the next edge.
    task automatic load(input int g, input logic [N-1:0] m);
        src_rdy[g] = 1'b1;
        mask[g]    = m;
        probe(g, P_ACK, 1, "load_ack");
        tick();
        src_rdy[g] = 1'b0;
    endtask

    // Bounded wait for outstanding beats; a leftover entry fails the qempty probe.
    task automatic drain(input string nm);
        for (int i = 0; i < 40 && expq.size() != 0; i++) tick();
        tick();
        probe(0, P_QEMP, 0, nm);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            src_rdy[g] = 1'b0;
            mask[g]    = '0;
            dst_ack[g] = 1'b1;
            hold_v[g]  = 1'b0;
        end

        // Reset state
        tick();
        for (int g = 0; g < 3; g++) begin
            probe(g, P_ACK, 1, "reset_src_ack");
            probe(g, P_RDY, 0, "reset_dst_rdy");
            probe(g, P_IDX, 0, "reset_idx");
            probe(g, P_OH, 0, "reset_onehot");
            probe(g, P_LAST, 0, "reset_last");
            probe(g, P_EMP, 0, "reset_empty");
        end
        tick();
        rst = 1'b0;
        tick();

        // LSB-first scan, consecutive beats
        exp_beat(0, 0, 10'h001, 0, 0);
        exp_beat(0, 3, 10'h008, 0, 0);
        exp_beat(0, 6, 10'h040, 0, 0);
        exp_beat(0, 9, 10'h200, 1, 0);
        load(0, 10'b10_0100_1001);
        for (int i = 0; i < 4; i++) begin
            probe(0, P_RDY, 1, "lsb_streaming");
            tick();
        end
        probe(0, P_RDY, 0, "lsb_idle_after_last");
        drain("lsb_drained");

        // MSB-first scan
        exp_beat(1, 9, 10'h200, 0, 0);
        exp_beat(1, 6, 10'h040, 0, 0);
        exp_beat(1, 3, 10'h008, 0, 0);
        exp_beat(1, 0, 10'h001, 1, 0);
        load(1, 10'b10_0100_1001);
        for (int i = 0; i < 4; i++) begin
            probe(1, P_RDY, 1, "msb_streaming");
            tick();
        end
        probe(1, P_RDY, 0, "msb_idle_after_last");
        drain("msb_drained");

        // Clear-bit matching: only bit 0 is clear
        exp_beat(2, 0, 10'h001, 1, 0);
        load(2, 10'b11_1111_1110);
        probe(2, P_RDY, 1, "inv_single_beat");
        tick();
        probe(2, P_RDY, 0, "inv_idle_after");
        drain("inv_drained");

        // Backpressure on idx 3 for three cycles
        exp_beat(0, 0, 10'h001, 0, 0);
        exp_beat(0, 3, 10'h008, 0, 0);
        exp_beat(0, 6, 10'h040, 0, 0);
        exp_beat(0, 9, 10'h200, 1, 0);
        load(0, 10'b10_0100_1001);
        tick();
        dst_ack[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            probe(0, P_IDX, 3, "bp_idx_held");
            tick();
        end
        dst_ack[0] = 1'b1;
        drain("bp_drained");

        // Back-to-back masks, second presented on the acked last beat
        exp_beat(0, 0, 10'h001, 0, 0);
        exp_beat(0, 1, 10'h002, 1, 0);
        exp_beat(0, 9, 10'h200, 1, 0);
        load(0, 10'h003);
        probe(0, P_RDY, 1, "b2b_first_beat");
        tick();
        src_rdy[0] = 1'b1;
        mask[0]    = 10'h200;
        probe(0, P_ACK, 1, "b2b_src_ack_on_last");
        probe(0, P_LAST, 1, "b2b_last_flag");
        tick();
        src_rdy[0] = 1'b0;
        probe(0, P_RDY, 1, "b2b_no_bubble");
        probe(0, P_IDX, 9, "b2b_second_idx");
        tick();
        probe(0, P_RDY, 0, "b2b_idle_after");
        drain("b2b_drained");

        // All-zero mask
`ifdef BIT_SCAN_ITERATOR_EMPTY_BEAT_EN
        exp_beat(0, 0, 10'h000, 1, 1);
        load(0, 10'h000);
        probe(0, P_RDY, 1, "empty_beat_present");
        tick();
        probe(0, P_RDY, 0, "empty_idle_after");
`else
        load(0, 10'h000);
        probe(0, P_RDY, 0, "empty_no_beat");
        probe(0, P_ACK, 1, "empty_still_ready");
        tick();
        probe(0, P_RDY, 0, "empty_no_beat_later");
`endif
        drain("empty_drained");

        // Reset during the second beat of 0x3FF
        exp_beat(0, 0, 10'h001, 0, 0);
        load(0, 10'h3FF);
        tick();
        rst        = 1'b1;
        dst_ack[0] = 1'b0;
        probe(0, P_IDX, 1, "rst_second_beat_shown");
        tick();
        rst        = 1'b0;
        dst_ack[0] = 1'b1;
        probe(0, P_RDY, 0, "rst_dst_rdy_cleared");
        probe(0, P_ACK, 1, "rst_src_ack_set");
        tick();
        exp_beat(0, 2, 10'h004, 1, 0);
        load(0, 10'h004);
        probe(0, P_RDY, 1, "post_rst_beat");
        tick();
        probe(0, P_RDY, 0, "post_rst_idle");
        drain("post_rst_drained");

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
